// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide sequencer owning HI/LO.
// Raises a D-stage stall while a HI/LO consumer would see stale data.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        d_uses_md,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [2:0] OP_MULT = 3'd1, OP_MULTU = 3'd2, OP_DIV = 3'd3, OP_DIVU = 3'd4;
  localparam logic [2:0] OP_MTHI = 3'd5, OP_MTLO = 3'd6;
  typedef enum logic {IDLE, RUN} state_t;
  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [31:0]    a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic [2:0]     op_q, op_d;
  logic           md_start, is_mul, sa, sb, wr_res;
  logic [31:0]    ua, ub, uq, ur;
  logic [63:0]    prod, res;
  assign md_start = start && md_op >= OP_MULT && md_op <= OP_DIVU;
  assign busy  = state_q == RUN;
  assign stall = d_uses_md && (busy || md_start);
  assign hi = hi_q;
  assign lo = lo_q;
  // Signed divide via magnitudes keeps INT_MIN / -1 well defined (quotient wraps to INT_MIN).
  assign is_mul = op_q == OP_MULT || op_q == OP_MULTU;
  assign sa = op_q == OP_DIV && a_q[31];
  assign sb = op_q == OP_DIV && b_q[31];
  assign ua = sa ? -a_q : a_q;
  assign ub = sb ? -b_q : b_q;
  assign uq = ua / ub;
  assign ur = ua % ub;
  assign prod = {{32{a_q[31] && op_q == OP_MULT}}, a_q} * {{32{b_q[31] && op_q == OP_MULT}}, b_q};
  assign res = is_mul ? prod : {sa ? -ur : ur, (sa ^ sb) ? -uq : uq};
  assign wr_res = is_mul || b_q != 32'd0;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (state_q == IDLE) begin
      if (md_start) begin
        state_d = RUN;
        a_d     = A;
        b_d     = B;
        op_d    = md_op;
        cnt_d   = md_op <= OP_MULTU ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
      end
      hi_d = start && md_op == OP_MTHI ? A : hi_q;
      lo_d = start && md_op == OP_MTLO ? A : lo_q;
    end else begin
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CW'(1)) begin
        state_d = IDLE;
        hi_d    = wr_res ? res[63:32] : hi_q;
        lo_d    = wr_res ? res[31:0] : lo_q;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed plus randomized checks of md_unit against an arithmetic reference model.
module tb_md_unit;
  localparam int MC = 5;
  localparam int DC = 10;
  logic clk, rst_n, start, d_uses_md, busy, stall;
  logic [2:0] md_op;
  logic [31:0] A, B, hi, lo;
  int checks = 0, errors = 0;
  int m_left;
  logic [31:0] m_hi, m_lo, m_a, m_b;
  logic [2:0] m_op;
  logic st0;

  md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .md_op(md_op), .A(A), .B(B),
    .d_uses_md(d_uses_md), .busy(busy), .stall(stall), .hi(hi), .lo(lo));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // {hi,lo} after completion, straight from the arithmetic definition of each op
  function automatic logic [63:0] model_res(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [63:0] old);
    int sa, sb;
    longint p;
    longint unsigned up;
    sa = a;
    sb = b;
    case (op)
      3'd1: begin p = longint'(sa) * longint'(sb); return p; end
      3'd2: begin up = {32'd0, a}; up = up * {32'd0, b}; return up; end
      3'd3: begin
        if (b == 0) return old;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
        return {32'(sa % sb), 32'(sa / sb)};
      end
      3'd4: begin
        if (b == 0) return old;
        return {a % b, a / b};
      end
      default: return old;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0;
      m_hi   <= '0;
      m_lo   <= '0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) {m_hi, m_lo} <= model_res(m_op, m_a, m_b, {m_hi, m_lo});
    end else if (start) begin
      if (md_op >= 3'd1 && md_op <= 3'd4) begin
        m_left <= md_op <= 3'd2 ? MC : DC;
        m_op   <= md_op;
        m_a    <= A;
        m_b    <= B;
      end
      if (md_op == 3'd5) m_hi <= A;
      if (md_op == 3'd6) m_lo <= A;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", {31'd0, busy}, {31'd0, m_left > 0});
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
      chk("stall", {31'd0, stall},
          {31'd0, d_uses_md && (m_left > 0 || (start && md_op >= 3'd1 && md_op <= 3'd4))});
    end
  end

  // Called at posedge+1; returns at the following posedge+1 with start dropped.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    md_op = op;
    A = a;
    B = b;
    @(negedge clk);
    st0 = stall;
    @(posedge clk);
    #1;
    start = 1'b0;
    md_op = 3'd0;
    A = $urandom;
    B = $urandom;
  endtask

  task automatic wait_done(output int nb, output int ns);
    nb = 0;
    ns = 0;
    while (busy && nb < 50) begin
      nb++;
      if (stall) ns++;
      @(posedge clk);
      #1;
    end
    if (busy) chk("timeout", 32'd1, 32'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 6)
      0: return 32'h0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return $urandom % 16;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int nb, ns;
    rst_n = 1'b0;
    start = 1'b0;
    md_op = 3'd0;
    A = '0;
    B = '0;
    d_uses_md = 1'b0;
    #2;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(3'd1, 32'hFFFFFFFF, 32'h2);
    wait_done(nb, ns);
    chk("mult_cycles", nb, 32'd5);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFFE);
    issue(3'd2, 32'hFFFFFFFF, 32'h2);
    wait_done(nb, ns);
    chk("multu_hi", hi, 32'h1);
    chk("multu_lo", lo, 32'hFFFFFFFE);
    d_uses_md = 1'b1;
    issue(3'd3, 32'hFFFFFFF9, 32'h2);
    chk("div_stall_start", {31'd0, st0}, 32'd1);
    wait_done(nb, ns);
    chk("div_cycles", nb, 32'd10);
    chk("div_stall_cycles", ns, 32'd10);
    chk("div_stall_after", {31'd0, stall}, 32'd0);
    chk("div_lo", lo, 32'hFFFFFFFD);
    chk("div_hi", hi, 32'hFFFFFFFF);
    d_uses_md = 1'b0;
    issue(3'd4, 32'd7, 32'd2);
    wait_done(nb, ns);
    chk("divu_lo", lo, 32'd3);
    chk("divu_hi", hi, 32'd1);
    issue(3'd5, 32'h12345678, 32'h0);
    chk("mthi_hi", hi, 32'h12345678);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    issue(3'd6, 32'h9ABCDEF0, 32'h0);
    chk("mtlo_lo", lo, 32'h9ABCDEF0);
    chk("mtlo_hi", hi, 32'h12345678);
    issue(3'd4, 32'd5, 32'd0);
    wait_done(nb, ns);
    chk("div0_cycles", nb, 32'd10);
    chk("div0_hi", hi, 32'h12345678);
    chk("div0_lo", lo, 32'h9ABCDEF0);
    issue(3'd3, 32'h80000000, 32'hFFFFFFFF);
    wait_done(nb, ns);
    chk("ovf_lo", lo, 32'h80000000);
    chk("ovf_hi", hi, 32'h0);
    issue(3'd1, 32'd3, 32'd4);
    @(posedge clk);
    #1;
    issue(3'd6, 32'hDEAD, 32'h0);
    wait_done(nb, ns);
    chk("ign_hi", hi, 32'h0);
    chk("ign_lo", lo, 32'd12);
    issue(3'd1, 32'h10000, 32'h10000);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_hi", hi, 32'h0);
    chk("arst_lo", lo, 32'h0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("post_rst_hi", hi, 32'h0);
    chk("post_rst_lo", lo, 32'h0);
    issue(3'd2, 32'd2, 32'd3);
    wait_done(nb, ns);
    chk("post_rst_cycles", nb, 32'd5);
    chk("post_rst_mlo", lo, 32'd6);
    chk("post_rst_mhi", hi, 32'd0);
    for (int i = 0; i < 600; i++) begin
      start = ($urandom % 3) == 0;
      md_op = 3'($urandom % 8);
      A = pick();
      B = pick();
      d_uses_md = 1'($urandom % 2);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    repeat (DC + 2) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
